// File: rtl/mux_2to1.sv
// mux_2to1: parameterizable 2:1 word selector.
// mux_out is a purely combinational pick of a_in/b_in. mux_out_q and control_q
// are registered copies for pipelined consumers, and they are the only state
// that clk and rst touch.
module mux_2to1 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             control,
    output logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] mux_out_q,
    output logic             control_q
);

    // Select the word: only a definite 1 on control picks b_in; 0, X or Z fall back to a_in.
    always_comb begin
        // NOTE: mux_out gets a default before the if. Every path then assigns it, so no latch is inferred.
        mux_out = a_in;
        if (control == 1'b1) begin
            mux_out = b_in;
        end
    end

    // Registered copy of the selected word and of control. The reset is synchronous and clears only these outputs.
    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so that every flop samples the values that were present before the edge.
        if (rst) begin
            mux_out_q <= '0;
            control_q <= 1'b0;
        end else begin
            mux_out_q <= mux_out;
            control_q <= control;
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: scoreboard bench for mux_2to1 with a 64-bit and a 5-bit instance.
// The two instances share clk and rst. The driver computes the expected outputs
// from the selection rule and pushes them into queues. Separate monitors pop
// those values and compare them with the outputs of both instances.
module tb_mux_2to1;

    localparam int W  = 64;
    localparam int W5 = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a, b, m, mq;
    logic          ctrl = 1'b0, cq;
    logic [W5-1:0] a5, b5, m5, mq5;
    logic          ctrl5 = 1'b0, cq5;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(W)) dut64 (
        .clk(clk), .rst(rst), .a_in(a), .b_in(b), .control(ctrl),
        .mux_out(m), .mux_out_q(mq), .control_q(cq)
    );

    mux_2to1 #(.WIDTH(W5)) dut5 (
        .clk(clk), .rst(rst), .a_in(a5), .b_in(b5), .control(ctrl5),
        .mux_out(m5), .mux_out_q(mq5), .control_q(cq5)
    );

    typedef struct {
        logic [W-1:0]  m;
        logic [W-1:0]  q_hold;
        logic [W5-1:0] m5;
        logic [W5-1:0] q5_hold;
    } comb_exp_t;

    typedef struct {
        logic [W-1:0]  q;
        logic          cq;
        logic [W5-1:0] q5;
        logic          cq5;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];
    event      comb_ev;

    // Reference model state: what the registered outputs hold right now.
    logic [W-1:0]  mdl_q   = '0;
    logic          mdl_cq  = 1'b0;
    logic [W5-1:0] mdl_q5  = '0;
    logic          mdl_cq5 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one vector at the falling edge, record the expectations, and run through the next rising edge.
    task automatic apply(input logic r, input logic c, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c5, input logic [W5-1:0] a5v, input logic [W5-1:0] b5v);
        comb_exp_t ce;
        reg_exp_t  re;
        rst = r; ctrl = c; a = av; b = bv;
        ctrl5 = c5; a5 = a5v; b5 = b5v;
        ce.m       = (ctrl === 1'b1) ? b : a;
        ce.m5      = (ctrl5 === 1'b1) ? b5 : a5;
        ce.q_hold  = mdl_q;
        ce.q5_hold = mdl_q5;
        comb_q.push_back(ce);
        -> comb_ev;
        re.q   = rst ? '0 : ce.m;
        re.cq  = rst ? 1'b0 : ctrl;
        re.q5  = rst ? '0 : ce.m5;
        re.cq5 = rst ? 1'b0 : ctrl5;
        reg_q.push_back(re);
        @(posedge clk);
        mdl_q = re.q; mdl_cq = re.cq; mdl_q5 = re.q5; mdl_cq5 = re.cq5;
        @(negedge clk);
    endtask

    // Combinational monitor: 1 time unit after each input change, mux_out must already be correct and mux_out_q must be unchanged.
    always begin
        comb_exp_t e;
        @(comb_ev);
        #1;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check("mux_out_w64", 128'(m), 128'(e.m));
            check("mux_out_w5", 128'(m5), 128'(e.m5));
            check("mux_out_q_hold_w64", 128'(mq), 128'(e.q_hold));
            check("mux_out_q_hold_w5", 128'(mq5), 128'(e.q5_hold));
        end
    end

    // Registered monitor: shortly after each rising edge, compare the captured outputs.
    always @(posedge clk) begin
        reg_exp_t e;
        #1;
        if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            check("mux_out_q_w64", 128'(mq), 128'(e.q));
            check("control_q_w64", 128'(cq), 128'(e.cq));
            check("mux_out_q_w5", 128'(mq5), 128'(e.q5));
            check("control_q_w5", 128'(cq5), 128'(e.cq5));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a = 64'd5; b = 64'd10; a5 = 5'd5; b5 = 5'd10;
        @(negedge clk);
        // Reset phase: mux_out tracks its inputs while the registers stay cleared.
        apply(1'b1, 1'b0, 64'd5, 64'd10,   1'b1, 5'd5,  5'd10);
        apply(1'b1, 1'b1, 64'd5, 64'd10,   1'b0, 5'd5,  5'd10);
        // Release reset; narrow-width sequence: the unselected b_in changes, then the selected a_in changes.
        apply(1'b0, 1'b0, 64'd5, 64'd10,   1'b0, 5'd5,  5'd11);
        apply(1'b0, 1'b1, 64'd5, 64'd10,   1'b0, 5'd22, 5'd11);
        // Reset asserted mid-operation for one edge, then the register reloads.
        apply(1'b1, 1'b1, 64'd5, 64'd10,   1'b1, 5'd22, 5'd11);
        apply(1'b0, 1'b1, 64'd5, 64'd10,   1'b1, 5'd22, 5'd11);
        // Signed pass-through, and a change on the unselected input.
        apply(1'b0, 1'b1, 64'd5, 64'(-350), 1'b1, 5'd3, 5'd31);
        apply(1'b0, 1'b1, 64'd999, 64'(-350), 1'b1, 5'd9, 5'd31);
        // Unknown control selects a_in.
        apply(1'b0, 1'bx, 64'd7, 64'd9,    1'bx, 5'd7,  5'd9);
        apply(1'b0, 1'b0, 64'd7, 64'd9,    1'b0, 5'd7,  5'd9);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 128'(comb_q.size() + reg_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Parameterizable-width 2:1 word selector used throughout the datapath: PC source, ALU operand B, write-back data, and 5-bit register-address selection.
- The primary output is purely combinational, so it is usable inside single-cycle paths.
- A registered copy of the selected word is also provided for pipelined consumers; this copy is the only use of the clock and reset.

Parameters:
- WIDTH, default 64 (the codebase `WORD value), bit width of both data inputs and both outputs; legal range 1..128. Instantiated at 64 for data and 5 for register addresses.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous reset, active-high; clears registered outputs only.
- a_in  input  WIDTH  data selected when control = 0.
- b_in  input  WIDTH  data selected when control = 1.
- control  input  1  select line.
- mux_out  output  WIDTH  combinational selected word.
- mux_out_q  output  WIDTH  registered copy of mux_out.
- control_q  output  1  registered copy of control (for downstream alignment).

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- mux_out = (control == 1) ? b_in : a_in.
  - Purely combinational, zero clock latency.
  - Must settle within the same time step as any input change; no dependence on clk or rst.
- control of 0, X or Z selects a_in (if/else semantics, not a ternary X-merge). Only a definite 1 selects b_in.
- Width rules:
  - Bit-exact pass-through; no sign extension, truncation or arithmetic.
  - Signed values pass unchanged, e.g. -350 at 64 bits = 0xFFFF_FFFF_FFFF_FEA2.
- The non-selected input has no effect on either output. Changing it while it is unselected must not change mux_out.
- Registered path, on each rising clk edge:
  - rst = 1: mux_out_q <= 0, control_q <= 0.
  - otherwise: mux_out_q <= mux_out, control_q <= control.
  - One cycle of latency relative to mux_out.
- Reset is sampled only at the clock edge. Asserting rst between edges does not affect mux_out_q until the next edge.
- mux_out is never affected by rst, including during reset.
- Simultaneous change of control and data in one time step:
  - mux_out reflects the new control and the new data.
  - mux_out_q captures the value present at the edge.
- No latches; the combinational always block must assign mux_out on every path.
- Multiple instances with different WIDTH may share clk/rst/control.

Test Plan:
- WIDTH=64, a_in=5, b_in=10, control=0 -> mux_out=5 within 1 time unit. Then control=1 -> mux_out=10.
- WIDTH=64, control=1, b_in=-350 (a_in=5) -> mux_out=-350 (signed decimal) with all upper bits set.
- WIDTH=5:
  - a_in=5, b_in=10, control=1 -> mux_out=10.
  - Then control=0 -> mux_out=5.
  - Then b_in=11 -> mux_out stays 5.
  - Then a_in=22 -> mux_out=22.
- Registered path, WIDTH=64:
  - rst=1 for 2 edges -> mux_out_q=0, control_q=0 while mux_out still tracks its inputs.
  - Release rst with a_in=5, control=0 -> mux_out_q=5 after the first edge.
  - control=1 with b_in=10 -> mux_out_q=10 one edge later.
- Reset mid-operation: with mux_out_q=10, assert rst for one edge -> mux_out_q=0 at that edge. Deassert -> reloads 10 on the following edge.
- control=X with a_in=7, b_in=9 -> mux_out=7.
